// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encodings and bit-timing derivation,
// so the transmitter and receiver agree on the same constants.
package uart_pkg;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StStop  = 2'd3;

    // Clock cycles per bit: f_MHz * 1e6 / baud_rate, truncated.
    function automatic int unsigned calc_t_baud(input int unsigned f_mhz,
                                                input int unsigned baud);
        return (f_mhz * 32'd1000000) / baud;
    endfunction

    // Cycles from the start-bit edge to its midpoint.
    function automatic int unsigned calc_half(input int unsigned t_baud);
        return t_baud / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit, with a configurable reset value.
module sync_2ff #(
    parameter logic ResetVal = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of a synchronized RX line, LSB-first, one stop bit,
// with a single-entry output register guarded by a valid/ack handshake.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned n         = 8,
    parameter int unsigned f_MHz     = 50,
    parameter int unsigned baud_rate = 9600
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         RX,
    input  logic         data_ack,
    output logic [n-1:0] data_out,
    output logic         data_valid,
    output logic         frame_err,
    output logic         overrun,
    output logic         busy
);

    localparam int unsigned TBaud = calc_t_baud(f_MHz, baud_rate);
    localparam int unsigned Half  = calc_half(TBaud);
    localparam int unsigned CntTW = (TBaud > 1) ? $clog2(TBaud) : 1;
    localparam int unsigned CntIW = $clog2(n + 1);

    localparam logic [CntTW-1:0] BitLast  = CntTW'(TBaud - 1);
    localparam logic [CntTW-1:0] HalfLast = CntTW'(Half - 1);
    localparam logic [CntTW-1:0] CntTOne  = CntTW'(1);
    localparam logic [CntIW-1:0] DataLast = CntIW'(n - 1);
    localparam logic [CntIW-1:0] CntIOne  = CntIW'(1);

    logic rx_s;

    logic [1:0]       state_q, state_d;
    logic [CntTW-1:0] cnt_t_q, cnt_t_d;
    logic [CntIW-1:0] cnt_i_q, cnt_i_d;
    logic [n-1:0]     shift_q, shift_d;
    logic [n-1:0]     data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    sync_2ff #(
        .ResetVal (1'b1)
    ) u_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (RX),
        .q_o   (rx_s)
    );

    always_comb begin
        state_d      = state_q;
        cnt_t_d      = cnt_t_q;
        cnt_i_d      = cnt_i_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;

        // An ack only matters while data is pending; a completing frame below re-arms valid.
        if (data_ack) begin
            data_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    state_d = StStart;
                    cnt_t_d = '0;
                end
            end
            StStart: begin
                if (cnt_t_q == HalfLast) begin
                    cnt_t_d = '0;
                    if (!rx_s) begin
                        state_d = StData;
                        cnt_i_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_t_d = cnt_t_q + CntTOne;
                end
            end
            StData: begin
                if (cnt_t_q == BitLast) begin
                    cnt_t_d        = '0;
                    shift_d        = shift_q >> 1;
                    shift_d[n-1]   = rx_s;
                    cnt_i_d        = cnt_i_q + CntIOne;
                    if (cnt_i_q == DataLast) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_t_d = cnt_t_q + CntTOne;
                end
            end
            StStop: begin
                if (cnt_t_q == BitLast) begin
                    cnt_t_d = '0;
                    state_d = StIdle;
                    if (rx_s) begin
                        data_out_d   = shift_q;
                        data_valid_d = 1'b1;
                        overrun_d    = data_valid_q & ~data_ack;
                    end else begin
                        frame_err_d  = 1'b1;
                    end
                end else begin
                    cnt_t_d = cnt_t_q + CntTOne;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_t_q      <= '0;
            cnt_i_q      <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_t_q      <= cnt_t_d;
            cnt_i_q      <= cnt_i_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 10 cycles per bit: directed scenarios plus randomized frames
// checked against a frame-level model of the valid/ack/overrun/frame-error rules.
module tb_uart_rx;

    localparam int unsigned N    = 8;
    localparam int unsigned FMHZ = 1;
    localparam int unsigned BAUD = 100000;
    localparam int          TB   = 10;
    localparam int          HALF = 5;
    localparam int          LAT  = 2 + HALF + (N + 1) * TB;

    logic         clk = 1'b0;
    logic         rst;
    logic         RX;
    logic         data_ack;
    logic [N-1:0] data_out;
    logic         data_valid;
    logic         frame_err;
    logic         overrun;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    // Frame-level reference state
    logic [N-1:0] exp_data  = '0;
    logic         exp_valid = 1'b0;
    int           exp_ovr   = 0;
    int           exp_ferr  = 0;
    int           last_e0   = 0;

    // Event counters kept by the monitor only
    int   cyc         = 0;
    int   dv_rises    = 0;
    int   dv_rise_cyc = 0;
    int   ferr_pulses = 0;
    int   ferr_hi     = 0;
    int   ovr_pulses  = 0;
    int   ovr_hi      = 0;
    int   busy_hits   = 0;
    logic dv_p = 1'b0;
    logic fe_p = 1'b0;
    logic ov_p = 1'b0;

    uart_rx #(
        .n         (N),
        .f_MHz     (FMHZ),
        .baud_rate (BAUD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RX         (RX),
        .data_ack   (data_ack),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid && !dv_p) begin
            dv_rises    <= dv_rises + 1;
            dv_rise_cyc <= cyc;
        end
        if (frame_err && !fe_p) ferr_pulses <= ferr_pulses + 1;
        if (frame_err) ferr_hi <= ferr_hi + 1;
        if (overrun && !ov_p) ovr_pulses <= ovr_pulses + 1;
        if (overrun) ovr_hi <= ovr_hi + 1;
        if (busy) busy_hits <= busy_hits + 1;
        dv_p <= data_valid;
        fe_p <= frame_err;
        ov_p <= overrun;
    end

    // Called at posedge+1; returns at posedge+1 after 10 bit times. ack_at is the edge
    // offset (0 = edge that first samples the start bit) carrying data_ack=1, or -1.
    task automatic send_frame(input logic [N-1:0] d, input logic stop, input int ack_at);
        logic [N+1:0] bits;
        bits    = {stop, d, 1'b0};
        last_e0 = cyc + 1;
        for (int c = 0; c < (N + 2) * TB; c++) begin
            RX       = bits[c / TB];
            data_ack = (c == ack_at);
            @(posedge clk);
            #1;
        end
        RX       = 1'b1;
        data_ack = 1'b0;
    endtask

    // A frame completes on edge LAT; acks before it clear old data, acks after it clear new.
    task automatic model_frame(input logic [N-1:0] d, input logic stop, input int ack_at);
        if (ack_at >= 0 && ack_at < LAT) exp_valid = 1'b0;
        if (stop) begin
            if (exp_valid && ack_at != LAT) exp_ovr++;
            exp_valid = 1'b1;
            exp_data  = d;
        end else begin
            exp_ferr++;
            if (ack_at == LAT) exp_valid = 1'b0;
        end
        if (ack_at > LAT) exp_valid = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack_pulse();
        data_ack = 1'b1;
        @(posedge clk);
        #1;
        data_ack  = 1'b0;
        exp_valid = 1'b0;
    endtask

    task automatic test_reset();
        int b_busy;
        rst      = 1'b1;
        RX       = 1'b1;
        data_ack = 1'b0;
        idle(3);
        checks++;
        if ({data_out, data_valid, frame_err, overrun, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %0h required 0",
                     {data_out, data_valid, frame_err, overrun, busy});
        end
        rst    = 1'b0;
        b_busy = busy_hits;
        idle(20);
        checks++;
        if (busy_hits != b_busy) begin
            failures++;
            $display("FAIL reset_quiet_line: busy cycles got %0d required 0", busy_hits - b_busy);
        end
    endtask

    task automatic test_single();
        int b_dv   = dv_rises;
        int b_fe   = ferr_pulses;
        int b_ov   = ovr_pulses;
        int b_busy = busy_hits;
        send_frame(8'hA5, 1'b1, -1);
        model_frame(8'hA5, 1'b1, -1);
        idle(5);
        checks++;
        if (data_out !== exp_data || data_valid !== exp_valid) begin
            failures++;
            $display("FAIL single_data: got %0h/%0b required %0h/%0b",
                     data_out, data_valid, exp_data, exp_valid);
        end
        checks++;
        if (dv_rises - b_dv != 1 || dv_rise_cyc - last_e0 != LAT) begin
            failures++;
            $display("FAIL single_latency: got %0d cycles (%0d rises) required %0d",
                     dv_rise_cyc - last_e0, dv_rises - b_dv, LAT);
        end
        checks++;
        if (ferr_pulses != b_fe || ovr_pulses != b_ov) begin
            failures++;
            $display("FAIL single_flags: got ferr=%0d ovr=%0d required 0/0",
                     ferr_pulses - b_fe, ovr_pulses - b_ov);
        end
        checks++;
        if (busy_hits == b_busy || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_busy: got cycles=%0d now=%0b required >0 and 0",
                     busy_hits - b_busy, busy);
        end
        ack_pulse();
        checks++;
        if (data_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_ack: got valid=%0b required 0", data_valid);
        end
    endtask

    task automatic test_glitch();
        int b_dv   = dv_rises;
        int b_fe   = ferr_pulses;
        int b_busy = busy_hits;
        RX = 1'b0;
        idle(3);
        RX = 1'b1;
        idle(20);
        checks++;
        if (busy_hits == b_busy || busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch_busy: got cycles=%0d now=%0b required >0 and 0",
                     busy_hits - b_busy, busy);
        end
        checks++;
        if (dv_rises != b_dv || ferr_pulses != b_fe || data_valid !== 1'b0) begin
            failures++;
            $display("FAIL glitch_flags: got dv=%0d ferr=%0d required 0/0",
                     dv_rises - b_dv, ferr_pulses - b_fe);
        end
    endtask

    task automatic test_frame_err();
        int b_fe = ferr_pulses;
        int b_fh = ferr_hi;
        send_frame(8'h3C, 1'b0, -1);
        model_frame(8'h3C, 1'b0, -1);
        idle(15);
        checks++;
        if (ferr_pulses - b_fe != 1 || ferr_hi - b_fh != 1) begin
            failures++;
            $display("FAIL ferr_pulse: got pulses=%0d cycles=%0d required 1/1",
                     ferr_pulses - b_fe, ferr_hi - b_fh);
        end
        checks++;
        if (data_valid !== 1'b0 || data_out !== exp_data) begin
            failures++;
            $display("FAIL ferr_hold: got %0h/%0b required %0h/0", data_out, data_valid, exp_data);
        end
        send_frame(8'h55, 1'b1, -1);
        model_frame(8'h55, 1'b1, -1);
        idle(3);
        checks++;
        if (data_out !== 8'h55 || data_valid !== 1'b1) begin
            failures++;
            $display("FAIL ferr_recover: got %0h/%0b required 55/1", data_out, data_valid);
        end
        ack_pulse();
    endtask

    task automatic test_back_to_back();
        int b_ov = ovr_pulses;
        int b_oh = ovr_hi;
        send_frame(8'h11, 1'b1, -1);
        model_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        model_frame(8'h22, 1'b1, -1);
        idle(3);
        checks++;
        if (ovr_pulses - b_ov != 1 || ovr_hi - b_oh != 1) begin
            failures++;
            $display("FAIL b2b_overrun: got pulses=%0d cycles=%0d required 1/1",
                     ovr_pulses - b_ov, ovr_hi - b_oh);
        end
        checks++;
        if (data_out !== 8'h22 || data_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_data: got %0h/%0b required 22/1", data_out, data_valid);
        end
        ack_pulse();
        b_ov = ovr_pulses;
        send_frame(8'h11, 1'b1, -1);
        model_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, LAT);
        model_frame(8'h22, 1'b1, LAT);
        idle(3);
        checks++;
        if (ovr_pulses != b_ov || data_out !== 8'h22 || data_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ack_same_cycle: got ovr=%0d %0h/%0b required 0 22/1",
                     ovr_pulses - b_ov, data_out, data_valid);
        end
    endtask

    task automatic test_reset_mid();
        int b_dv;
        int b_fe;
        int b_ov;
        // data_valid is still 1 from the previous test, so the clear is observable
        RX = 1'b0;
        idle(TB);
        RX = 1'b1;
        idle(4 * TB + HALF);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({data_out, data_valid, frame_err, overrun, busy} !== '0) begin
            failures++;
            $display("FAIL reset_async: got %0h required 0",
                     {data_out, data_valid, frame_err, overrun, busy});
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checks++;
        if ({data_out, data_valid, frame_err, overrun, busy} !== '0) begin
            failures++;
            $display("FAIL reset_hold: got %0h required 0",
                     {data_out, data_valid, frame_err, overrun, busy});
        end
        rst       = 1'b0;
        exp_valid = 1'b0;
        exp_data  = '0;
        b_dv = dv_rises;
        b_fe = ferr_pulses;
        b_ov = ovr_pulses;
        idle(5 * TB);
        checks++;
        if (busy !== 1'b0 || dv_rises != b_dv || ferr_pulses != b_fe) begin
            failures++;
            $display("FAIL reset_abandon: got busy=%0b dv=%0d ferr=%0d required 0/0/0",
                     busy, dv_rises - b_dv, ferr_pulses - b_fe);
        end
        send_frame(8'h81, 1'b1, -1);
        model_frame(8'h81, 1'b1, -1);
        idle(3);
        checks++;
        if (data_out !== 8'h81 || data_valid !== 1'b1 || ferr_pulses != b_fe
            || ovr_pulses != b_ov) begin
            failures++;
            $display("FAIL reset_next_frame: got %0h/%0b ferr=%0d ovr=%0d required 81/1/0/0",
                     data_out, data_valid, ferr_pulses - b_fe, ovr_pulses - b_ov);
        end
    endtask

    task automatic test_random();
        int b_fe = ferr_pulses;
        int b_ov = ovr_pulses;
        int m_fe = exp_ferr;
        int m_ov = exp_ovr;
        logic [N-1:0] d;
        logic stop;
        int ack_at;
        for (int k = 0; k < 30; k++) begin
            d      = N'($urandom);
            stop   = ($urandom_range(0, 4) != 0);
            ack_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, (N + 2) * TB - 1)) : -1;
            if (k % 7 == 3) ack_at = LAT;
            send_frame(d, stop, ack_at);
            model_frame(d, stop, ack_at);
            checks++;
            if (data_out !== exp_data || data_valid !== exp_valid) begin
                failures++;
                $display("FAIL rand_data[%0d]: got %0h/%0b required %0h/%0b",
                         k, data_out, data_valid, exp_data, exp_valid);
            end
            checks++;
            if (ferr_pulses - b_fe != exp_ferr - m_fe || ovr_pulses - b_ov != exp_ovr - m_ov) begin
                failures++;
                $display("FAIL rand_flags[%0d]: got ferr=%0d ovr=%0d required %0d/%0d", k,
                         ferr_pulses - b_fe, ovr_pulses - b_ov, exp_ferr - m_fe, exp_ovr - m_ov);
            end
            idle(int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter n, default 8, meaning data bits per frame.
REQ-002 The block SHALL have parameter f_MHz, default 50, meaning clock frequency in MHz.
REQ-003 The block SHALL have parameter baud_rate, default 9600, meaning line bit rate.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port RX, input, 1 bit: asynchronous serial line, idle high.
REQ-007 The block SHALL have port data_ack, input, 1 bit: consumer acknowledges data_out.
REQ-008 The block SHALL have port data_out, output, n bits: last received byte.
REQ-009 The block SHALL have port data_valid, output, 1 bit: data_out holds unconsumed data.
REQ-010 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-011 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when unconsumed data is overwritten.
REQ-012 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 RX SHALL pass through a 2-flop synchronizer (rx_s); all decisions SHALL use rx_s only.
REQ-014 The block SHALL compute T_baud = f_MHz*1000000/baud_rate and HALF = T_baud/2 (integer); the bit-time counter SHALL be $clog2(T_baud) wide and the bit counter $clog2(n+1) wide.
REQ-015 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-016 In IDLE with rx_s=0, the FSM SHALL go to START with cnt_t=0.
REQ-017 In START at cnt_t=HALF-1, the FSM SHALL go to DATA (cnt_t=0, cnt_i=0) if rx_s=0, else return to IDLE (glitch reject) with no flag.
REQ-018 In DATA at cnt_t=T_baud-1, the block SHALL shift rx_s into the shift register LSB-first (enter at MSB, shift right), clear cnt_t and increment cnt_i.
REQ-019 After the n-th data sample, the FSM SHALL go to STOP.
REQ-020 In STOP at cnt_t=T_baud-1 with rx_s=1, the block SHALL load data_out with the shift register and set data_valid in the same edge, then go to IDLE.
REQ-021 In STOP at cnt_t=T_baud-1 with rx_s=0, the block SHALL pulse frame_err for 1 cycle, leave data_out and data_valid unchanged, and go to IDLE.
REQ-022 After STOP (either outcome), the block SHALL resynchronise and detect the next start bit immediately, roughly half a bit early.
REQ-023 Latency SHALL be exactly 2 + HALF + (n+1)*T_baud cycles from the clk edge that samples RX low to data_valid high.
REQ-024 data_valid SHALL stay high until a clk edge with data_ack=1 and then clear; data_ack while data_valid=0 SHALL be ignored.
REQ-025 If a frame completes while data_valid=1 and data_ack=0, the block SHALL overwrite data_out, keep data_valid=1 and pulse overrun.
REQ-026 If a frame completes in the same cycle that data_ack=1, the block SHALL load the new data, keep data_valid=1, and SHALL NOT pulse overrun.
REQ-027 busy SHALL be high in START, DATA and STOP.

Reset
REQ-028 On rst high, regardless of clk, the block SHALL set: FSM to IDLE; cnt_t and cnt_i to 0; shift register and data_out to 0; data_valid, frame_err, overrun and busy to 0; both synchronizer flops to 1.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no flag; after release the block SHALL wait in IDLE for a fresh falling edge.

Structure
REQ-030 The state encodings and the T_baud/HALF derivation SHALL live in shared package uart_pkg, so the transmitter uses the same timing constants.
REQ-031 The synchronizer SHALL be the single sub-module, sync_2ff (1-bit, reset value 1).
REQ-032 The FSM, counters and shift register SHALL be in uart_rx itself.

Verification (f_MHz=1, baud_rate=100000 -> T_baud=10, HALF=5, n=8)
REQ-033 Frame 0xA5 sent LSB-first with stop=1 -> data_out=0xA5 and data_valid rising exactly 2+5+90=97 cycles after the start edge; frame_err=0 and overrun=0.
REQ-034 RX low for 3 cycles, then high -> FSM returns to IDLE, busy falls, and no data_valid or frame_err.
REQ-035 Frame 0x3C with stop bit=0 -> frame_err pulses for 1 cycle, data_valid stays 0, and the next valid frame 0x55 is received correctly.
REQ-036 Back-to-back frames 0x11 then 0x22 with no data_ack -> overrun pulses once, data_out=0x22 and data_valid=1; repeat with data_ack raised on the completion cycle -> no overrun.
REQ-037 rst pulsed during data bit 4 of 0xFF, then frame 0x81 sent -> all outputs are 0 during reset and 0x81 is received with no flags.
